// File: rtl/video_cfg_pkg.sv
// Shared definitions for the raster timing configuration block: register map,
// CTRL/STATUS bit positions, commit FSM states and the trim bundle.
package video_cfg_pkg;

    localparam logic [2:0] REG_OFFSET = 3'd0;
    localparam logic [2:0] REG_WIDTH  = 3'd1;
    localparam logic [2:0] REG_CTRL   = 3'd2;
    localparam logic [2:0] REG_RASTER = 3'd3;
    localparam logic [2:0] REG_STATUS = 3'd4;

    localparam int CTRL_VBL_EN     = 0;
    localparam int CTRL_RAS_EN     = 1;
    localparam int CTRL_COMMIT_REQ = 2;
    localparam int CTRL_COMMIT_NOW = 3;

    localparam int STAT_VBL_PEND = 0;
    localparam int STAT_RAS_PEND = 1;
    localparam int STAT_ARMED    = 2;

    typedef enum logic [1:0] {
        CMT_IDLE  = 2'd0,
        CMT_ARMED = 2'd1,
        CMT_APPLY = 2'd2
    } commit_state_e;

    typedef struct packed {
        logic signed [3:0] vs_ofs;
        logic signed [3:0] hs_ofs;
        logic signed [3:0] vs_w;
        logic signed [3:0] hs_w;
    } trim_t;

endpackage

// File: rtl/vid_irq_cell.sv
// One interrupt source: sticky pending bit with W1C acknowledge and a
// registered level interrupt gated by its enable.
module vid_irq_cell (
    input  logic clk,
    input  logic reset,
    input  logic set,
    input  logic ack,
    input  logic en,
    output logic pend,
    output logic irq
);

    logic pend_d, pend_q;
    logic irq_d, irq_q;

    // Next pending/irq: a set in the same cycle as an acknowledge must not be lost.
    always_comb begin
        pend_d = pend_q;
        if (set) begin
            pend_d = 1'b1;
        end else if (ack) begin
            pend_d = 1'b0;
        end else begin
            pend_d = pend_q;
        end
        irq_d = pend_q & en;
    end

    // Pending and interrupt flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            irq_q  <= irq_d;
        end
    end

    assign pend = pend_q;
    assign irq  = irq_q;

endmodule

// File: rtl/video_timing_cfg.sv
// CPU register block for the raster timing generator: staged trims committed at
// vblank start, vblank and raster-line interrupts. Raster compare needs RASTER_IRQ_EN.
module video_timing_cfg
    import video_cfg_pkg::*;
#(
    parameter logic signed [3:0] HS_OFS_DEF  = 4'sd0,
    parameter logic signed [3:0] VS_OFS_DEF  = 4'sd0,
    parameter logic signed [3:0] HS_W_DEF    = 4'sd0,
    parameter logic signed [3:0] VS_W_DEF    = 4'sd0,
    parameter logic [8:0]        RASTER_HPOS = 9'd256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_pix,
    input  logic [8:0]        hc,
    input  logic [8:0]        vc,
    input  logic              vbl,
    input  logic              cpu_cs,
    input  logic              cpu_we,
    input  logic [2:0]        cpu_addr,
    input  logic [15:0]       cpu_din,
    output logic [15:0]       cpu_dout,
    output logic signed [3:0] hs_offset,
    output logic signed [3:0] vs_offset,
    output logic signed [3:0] hs_width,
    output logic signed [3:0] vs_width,
    output logic              irq_vbl,
    output logic              irq_raster
);

`ifdef RASTER_IRQ_EN
    localparam logic RAS_ON = 1'b1;
`else
    localparam logic RAS_ON = 1'b0;
`endif

    localparam trim_t TRIM_DEF = '{vs_ofs: VS_OFS_DEF, hs_ofs: HS_OFS_DEF,
                                   vs_w: VS_W_DEF, hs_w: HS_W_DEF};

    trim_t         staged_d, staged_q, live_d, live_q;
    commit_state_e state_d, state_q;
    logic          vbl_en_d, vbl_en_q, ras_en_d, ras_en_q;
    logic [8:0]    raster_d, raster_q;
    logic [15:0]   dout_d, dout_q, rdata_s;
    logic          vbl_dly_q;
    logic          wr_s, rd_s, ctrl_wr_s, stat_wr_s, rise_s, ras_hit_s;
    logic          vbl_pend_s, vbl_irq_s, ras_pend_s, ras_irq_s;
    logic          unused_din_s;

    assign wr_s      = cpu_cs & cpu_we;
    assign rd_s      = cpu_cs & ~cpu_we;
    assign ctrl_wr_s = wr_s & (cpu_addr == REG_CTRL);
    assign stat_wr_s = wr_s & (cpu_addr == REG_STATUS);
    assign rise_s    = vbl & ~vbl_dly_q;
    assign ras_hit_s = RAS_ON & clk_pix & (hc == RASTER_HPOS) & (vc == raster_q);
    assign unused_din_s = ^cpu_din[15:9];

    // Register writes and commit sequencing; live trims only move in APPLY.
    always_comb begin
        staged_d = staged_q;
        live_d   = live_q;
        vbl_en_d = vbl_en_q;
        ras_en_d = ras_en_q;
        raster_d = raster_q;
        state_d  = state_q;
        if (wr_s) begin
            case (cpu_addr)
                REG_OFFSET: begin
                    staged_d.vs_ofs = cpu_din[7:4];
                    staged_d.hs_ofs = cpu_din[3:0];
                end
                REG_WIDTH: begin
                    staged_d.vs_w = cpu_din[7:4];
                    staged_d.hs_w = cpu_din[3:0];
                end
                REG_CTRL: begin
                    vbl_en_d = cpu_din[CTRL_VBL_EN];
                    ras_en_d = RAS_ON & cpu_din[CTRL_RAS_EN];
                end
                REG_RASTER: begin
                    if (RAS_ON) begin
                        raster_d = cpu_din[8:0];
                    end else begin
                        raster_d = raster_q;
                    end
                end
                default: begin
                    staged_d = staged_q;
                end
            endcase
        end else begin
            staged_d = staged_q;
        end

        case (state_q)
            CMT_IDLE: begin
                if (ctrl_wr_s && cpu_din[CTRL_COMMIT_REQ]) begin
                    state_d = CMT_ARMED;
                end else begin
                    state_d = CMT_IDLE;
                end
            end
            CMT_ARMED: begin
                if (rise_s) begin
                    state_d = CMT_APPLY;
                end else begin
                    state_d = CMT_ARMED;
                end
            end
            CMT_APPLY: begin
                live_d  = staged_q;
                state_d = CMT_IDLE;
            end
            default: begin
                state_d = CMT_IDLE;
            end
        endcase

        // Immediate commit overrides whatever the FSM was doing.
        if (ctrl_wr_s && cpu_din[CTRL_COMMIT_NOW]) begin
            state_d = CMT_APPLY;
        end else begin
            state_d = state_d;
        end
    end

    // Read mux and registered read data.
    always_comb begin
        rdata_s = 16'h0000;
        case (cpu_addr)
            REG_OFFSET: rdata_s = {8'h00, staged_q.vs_ofs, staged_q.hs_ofs};
            REG_WIDTH:  rdata_s = {8'h00, staged_q.vs_w, staged_q.hs_w};
            REG_CTRL:   rdata_s = {13'h0000, (state_q != CMT_IDLE), ras_en_q, vbl_en_q};
            REG_RASTER: rdata_s = {7'h00, raster_q};
            REG_STATUS: rdata_s = {3'b000, vc, 1'b0, (state_q == CMT_ARMED), ras_pend_s, vbl_pend_s};
            default:    rdata_s = 16'h0000;
        endcase
        if (rd_s) begin
            dout_d = rdata_s;
        end else begin
            dout_d = dout_q;
        end
    end

    // All block state.
    always_ff @(posedge clk) begin
        if (reset) begin
            staged_q  <= TRIM_DEF;
            live_q    <= TRIM_DEF;
            vbl_en_q  <= 1'b0;
            ras_en_q  <= 1'b0;
            raster_q  <= 9'd0;
            state_q   <= CMT_IDLE;
            dout_q    <= 16'h0000;
            vbl_dly_q <= 1'b0;
        end else begin
            staged_q  <= staged_d;
            live_q    <= live_d;
            vbl_en_q  <= vbl_en_d;
            ras_en_q  <= ras_en_d;
            raster_q  <= raster_d;
            state_q   <= state_d;
            dout_q    <= dout_d;
            vbl_dly_q <= vbl;
        end
    end

    vid_irq_cell u_vbl_irq (
        .clk   (clk),
        .reset (reset),
        .set   (rise_s),
        .ack   (stat_wr_s & cpu_din[STAT_VBL_PEND]),
        .en    (vbl_en_q),
        .pend  (vbl_pend_s),
        .irq   (vbl_irq_s)
    );

    vid_irq_cell u_ras_irq (
        .clk   (clk),
        .reset (reset),
        .set   (ras_hit_s),
        .ack   (stat_wr_s & cpu_din[STAT_RAS_PEND]),
        .en    (ras_en_q),
        .pend  (ras_pend_s),
        .irq   (ras_irq_s)
    );

    assign cpu_dout   = dout_q;
    assign hs_offset  = live_q.hs_ofs;
    assign vs_offset  = live_q.vs_ofs;
    assign hs_width   = live_q.hs_w;
    assign vs_width   = live_q.vs_w;
    assign irq_vbl    = vbl_irq_s;
    assign irq_raster = RAS_ON & ras_irq_s;

endmodule

// File: tb/tb_video_timing_cfg.sv
// Directed bench for video_timing_cfg; expected values are hand-computed.
// Raster checks follow the RASTER_IRQ_EN build setting.
module tb_video_timing_cfg;

    logic              clk = 1'b0;
    logic              reset, clk_pix, vbl, cpu_cs, cpu_we;
    logic [8:0]        hc, vc;
    logic [2:0]        cpu_addr;
    logic [15:0]       cpu_din, cpu_dout, rd;
    logic signed [3:0] hs_offset, vs_offset, hs_width, vs_width;
    logic              irq_vbl, irq_raster;
    int                n_vec = 0;
    int                n_err = 0;

    video_timing_cfg dut (
        .clk(clk), .reset(reset), .clk_pix(clk_pix), .hc(hc), .vc(vc), .vbl(vbl),
        .cpu_cs(cpu_cs), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_dout(cpu_dout), .hs_offset(hs_offset), .vs_offset(vs_offset),
        .hs_width(hs_width), .vs_width(vs_width), .irq_vbl(irq_vbl), .irq_raster(irq_raster)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cpu_write(input logic [2:0] a, input logic [15:0] d);
        cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_din = d;
        @(negedge clk);
        cpu_cs = 1'b0; cpu_we = 1'b0; cpu_din = 16'h0000;
    endtask

    task automatic cpu_read(input logic [2:0] a, output logic [15:0] d);
        cpu_cs = 1'b1; cpu_we = 1'b0; cpu_addr = a;
        @(negedge clk);
        cpu_cs = 1'b0;
        d = cpu_dout;
    endtask

    function automatic logic [15:0] trims();
        return {hs_offset, vs_offset, hs_width, vs_width};
    endfunction

    initial begin
        reset = 1'b1; clk_pix = 1'b0; vbl = 1'b0; hc = 9'd0; vc = 9'd50;
        cpu_cs = 1'b0; cpu_we = 1'b0; cpu_addr = 3'd0; cpu_din = 16'h0000;
        step(3);
        reset = 1'b0;
        step(1);

        // Reset state
        check_val("rst_dout", cpu_dout, 16'h0000);
        check_val("rst_trims", trims(), 16'h0000);
        check_val("rst_irqs", {14'h0, irq_vbl, irq_raster}, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            cpu_read(3'(i), rd);
            check_val($sformatf("rst_reg%0d", i), rd, 16'h0000);
        end
        cpu_read(3'd4, rd);
        check_val("rst_status", rd, 16'h0320);
        cpu_read(3'd6, rd);
        check_val("rst_reg6", rd, 16'h0000);

        // Staged offset committed at vblank rise
        cpu_write(3'd0, 16'h003F);
        cpu_write(3'd2, 16'h0004);
        cpu_read(3'd2, rd);
        check_val("ctrl_pending", rd, 16'h0004);
        cpu_read(3'd4, rd);
        check_val("status_armed", rd, 16'h0324);
        step(3);
        check_val("hs_before_vbl", {12'h0, hs_offset}, 16'h0000);
        vbl = 1'b1;
        step(1);
        check_val("hs_vbl_plus1", {12'h0, hs_offset}, 16'h0000);
        step(1);
        check_val("hs_vbl_plus2", {12'h0, hs_offset}, 16'h000F);
        check_val("vs_vbl_plus2", {12'h0, vs_offset}, 16'h0003);
        cpu_read(3'd4, rd);
        check_val("status_after_apply", rd, 16'h0321);
        cpu_write(3'd4, 16'h0001);
        cpu_read(3'd4, rd);
        check_val("status_w1c", rd, 16'h0320);
        vbl = 1'b0;
        step(2);

        // Immediate commit of widths
        cpu_write(3'd1, 16'h005A);
        cpu_write(3'd2, 16'h0008);
        check_val("hw_now_plus1", {12'h0, hs_width}, 16'h0000);
        step(1);
        check_val("hw_now_plus2", {12'h0, hs_width}, 16'h000A);
        check_val("vw_now_plus2", {12'h0, vs_width}, 16'h0005);
        cpu_read(3'd2, rd);
        check_val("ctrl_idle", rd, 16'h0000);

        // Vblank interrupt, W1C, enable clear
        cpu_write(3'd2, 16'h0001);
        vbl = 1'b1;
        step(1);
        check_val("irq_vbl_plus1", {15'h0, irq_vbl}, 16'h0000);
        step(1);
        check_val("irq_vbl_plus2", {15'h0, irq_vbl}, 16'h0001);
        cpu_write(3'd4, 16'h0001);
        step(1);
        check_val("irq_vbl_acked", {15'h0, irq_vbl}, 16'h0000);
        vbl = 1'b0;
        step(2);
        vbl = 1'b1;
        step(2);
        check_val("irq_vbl_again", {15'h0, irq_vbl}, 16'h0001);
        cpu_write(3'd2, 16'h0000);
        step(1);
        check_val("irq_vbl_en_off", {15'h0, irq_vbl}, 16'h0000);
        cpu_read(3'd4, rd);
        check_val("pend_retained", rd, 16'h0321);
        cpu_write(3'd4, 16'h0001);
        vbl = 1'b0;
        step(2);

        // Raster compare
        cpu_write(3'd3, 16'd100);
        cpu_write(3'd2, 16'h0002);
        vc = 9'd100; hc = 9'd255; clk_pix = 1'b1;
        step(1);
        hc = 9'd256; clk_pix = 1'b0;
        step(2);
`ifdef RASTER_IRQ_EN
        cpu_read(3'd3, rd);
        check_val("raster_reg", rd, 16'h0064);
        cpu_read(3'd4, rd);
        check_val("ras_no_hit", rd, 16'h0640);
        clk_pix = 1'b1;
        step(1);
        clk_pix = 1'b0;
        step(1);
        check_val("irq_ras_set", {15'h0, irq_raster}, 16'h0001);
        clk_pix = 1'b1;
        cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 3'd4; cpu_din = 16'h0002;
        step(1);
        clk_pix = 1'b0; cpu_cs = 1'b0; cpu_we = 1'b0; cpu_din = 16'h0000;
        step(1);
        check_val("irq_ras_set_wins", {15'h0, irq_raster}, 16'h0001);
        cpu_read(3'd4, rd);
        check_val("ras_pend_kept", rd, 16'h0642);
        cpu_write(3'd4, 16'h0002);
        step(1);
        check_val("irq_ras_acked", {15'h0, irq_raster}, 16'h0000);
`else
        cpu_read(3'd3, rd);
        check_val("raster_reg_off", rd, 16'h0000);
        cpu_read(3'd2, rd);
        check_val("ctrl_ras_off", rd, 16'h0000);
        clk_pix = 1'b1;
        step(1);
        clk_pix = 1'b0;
        step(2);
        check_val("irq_ras_off", {15'h0, irq_raster}, 16'h0000);
        cpu_read(3'd4, rd);
        check_val("status_ras_off", rd, 16'h0640);
`endif
        vc = 9'd50; hc = 9'd0;
        cpu_write(3'd2, 16'h0000);

        // Reset one clock before vblank rise while armed
        cpu_write(3'd0, 16'h0021);
        cpu_write(3'd2, 16'h0004);
        reset = 1'b1;
        step(1);
        reset = 1'b0; vbl = 1'b1;
        step(3);
        check_val("rst_armed_trims", trims(), 16'h0000);
        cpu_read(3'd2, rd);
        check_val("rst_armed_ctrl", rd, 16'h0000);
        cpu_read(3'd4, rd);
        check_val("rst_armed_status", rd, 16'h0321);
        cpu_read(3'd0, rd);
        check_val("rst_armed_offset", rd, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
